// File: rtl/imem_loader.sv
// Byte-stream loader that assembles little-endian IW-bit words and writes them to instruction memory.
// Optional trailing checksum byte and chk_err output are enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMW = 4,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [IMW:0]   len,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    output logic           byte_ready,
    output logic           im_we,
    output logic [IMW-1:0] im_waddr,
    output logic [IW-1:0]  im_wdata,
    output logic           busy,
    output logic           done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic           chk_err
`endif
);

    localparam int BPW = IW / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    // State entered once the image words are exhausted
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CHECK;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t          r_state;
    state_t          w_state_next;

    logic [BCW-1:0]  r_bcnt;
    logic [IMW:0]    r_words;
    logic [IMW:0]    r_widx;
    logic [IW-1:0]   r_word;
    logic            r_we;
    logic [IMW-1:0]  r_waddr;
    logic [IW-1:0]   r_wdata;
    logic            r_busy;
    logic            r_done;

    logic            w_xfer;
    logic            w_last_byte;
    logic [IMW:0]    w_widx_inc;
    logic [IMW:0]    w_words_start;
    logic [IW-1:0]   w_word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic            r_chk_err;
    logic [7:0]      w_sum_next;

    assign w_sum_next = r_sum + byte_data;
    assign chk_err    = r_chk_err;
`endif

    // Lengths at or beyond the memory depth clamp to a full-depth load
    assign w_words_start = len[IMW] ? {1'b1, {IMW{1'b0}}} : len;
    assign w_last_byte   = (r_bcnt == BCW'(BPW - 1));
    assign w_widx_inc    = r_widx + (IMW + 1)'(1);
    assign w_xfer        = byte_valid && byte_ready;

    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_bcnt, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (w_words_start == '0) ? S_LAST : S_COLLECT;
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                if (byte_valid && w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = (w_widx_inc == r_words) ? S_LAST : S_COLLECT;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt    <= '0;
            r_words   <= '0;
            r_widx    <= '0;
            r_word    <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= '0;
            r_chk_err <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
            r_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_words <= w_words_start;
                        r_widx  <= '0;
                        r_bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum     <= '0;
                        r_chk_err <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_word <= w_word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum  <= w_sum_next;
`endif
                        if (w_last_byte) begin
                            r_bcnt  <= '0;
                            r_we    <= 1'b1;
                            r_waddr <= r_widx[IMW-1:0];
                            r_wdata <= w_word_next;
                        end else begin
                            r_bcnt <= r_bcnt + BCW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_widx <= w_widx_inc;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_chk_err <= (w_sum_next != 8'h00);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign im_we    = r_we;
    assign im_waddr = r_waddr;
    assign im_wdata = r_wdata;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream sessions compared against hand-computed memory writes.
module tb_imem_loader;

    localparam int IMW = 4;
    localparam int IW  = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [IMW:0]   len = '0;
    logic           byte_valid = 1'b0;
    logic [7:0]     byte_data = 8'h00;
    logic           byte_ready;
    logic           im_we;
    logic [IMW-1:0] im_waddr;
    logic [IW-1:0]  im_wdata;
    logic           busy;
    logic           done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic           chk_err;
`endif

    imem_loader #(.IMW(IMW), .IW(IW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    logic [IMW-1:0] wa[$];
    logic [IW-1:0]  wd[$];
    logic [7:0]     img[$];
    logic [IW-1:0]  ew[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(im_waddr);
            wd.push_back(im_wdata);
            check("ready_in_write", 64'(byte_ready), 64'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_session(input int n_len, input bit toggle, input int poke_at, input int csum);
        logic [7:0] s;
        int budget;
        wa.delete();
        wd.delete();
        done_cnt = 0;
        s = 8'h00;
        foreach (img[i]) s = s + img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (csum < 0) img.push_back(8'h00 - s);
        else          img.push_back(csum[7:0]);
`endif
        @(negedge clk);
        start = 1'b1;
        len   = n_len[IMW:0];
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("busy_rise", 64'(busy), 64'd1);
        for (int i = 0; i < img.size(); i++) begin
            byte_valid = 1'b1;
            byte_data  = img[i];
            if (i == poke_at) begin
                start = 1'b1;
                len   = 1;
            end
            budget = 0;
            while (byte_ready !== 1'b1 && budget < 40) begin
                @(negedge clk);
                start = 1'b0;
                budget++;
            end
            if (budget >= 40) begin
                check("byte_wait_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
            start = 1'b0;
            if (toggle) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (csum < 0) check("chk_err_auto", 64'(chk_err), 64'd0);
`endif
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_nwr"}, 64'(wa.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wa.size(); i++) begin
            check({tag, "_addr"}, 64'(wa[i]), 64'(i));
            check({tag, "_data"}, 64'(wd[i]), 64'(ew[i]));
        end
        check({tag, "_done"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic load_basic_image();
        img = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        ew  = '{32'h00100013, 32'h00200093};
    endtask

    initial begin
        #1;
        check("rst_ready", 64'(byte_ready), 64'd0);
        check("rst_we",    64'(im_we),      64'd0);
        check("rst_waddr", 64'(im_waddr),   64'd0);
        check("rst_wdata", 64'(im_wdata),   64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_done",  64'(done),       64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'd0);

        load_basic_image();
        run_session(2, 1'b0, -1, -1);
        verify_writes("held");

        load_basic_image();
        run_session(2, 1'b1, -1, -1);
        verify_writes("toggle");

        // Abort a session after two bytes of word 0
        wa.delete();
        wd.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        len   = 1;
        @(negedge clk);
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h11;
        @(negedge clk);
        byte_data  = 8'h22;
        @(negedge clk);
        byte_valid = 1'b0;
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ready", 64'(byte_ready), 64'd0);
        check("abort_we",    64'(im_we),      64'd0);
        check("abort_waddr", 64'(im_waddr),   64'd0);
        check("abort_wdata", 64'(im_wdata),   64'd0);
        check("abort_busy",  64'(busy),       64'd0);
        check("abort_done",  64'(done),       64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_write", 64'(wa.size()), 64'd0);
        check("abort_no_done",  64'(done_cnt),  64'd0);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        ew  = '{32'hDDCCBBAA};
        run_session(1, 1'b0, -1, -1);
        verify_writes("after_abort");

        img.delete();
        ew.delete();
        run_session(0, 1'b0, -1, -1);
        verify_writes("len0");
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("len0_latency", 64'((done_cyc - start_cyc) <= 2), 64'd1);
`endif

        img.delete();
        ew.delete();
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 4; k++) img.push_back(8'(4 * w + k));
            ew.push_back({8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
        end
        run_session(31, 1'b0, -1, -1);
        verify_writes("len31");

        load_basic_image();
        run_session(2, 1'b0, 1, -1);
        verify_writes("start_poke");

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        ew  = '{32'h04030201};
        run_session(1, 1'b0, -1, 8'hF6);
        verify_writes("csum_good");
        check("csum_good_err", 64'(chk_err), 64'd0);
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1, 1'b0, -1, 8'h00);
        verify_writes("csum_bad");
        check("csum_bad_err", 64'(chk_err), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the fetch stage (program counter into instruction memory) is the reader side.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into IW-bit instruction words.
- Writes the words into instruction memory at consecutive addresses starting at 0.
- Holds off core fetch until the program image is fully loaded.

Parameters:
- IMW, 4, instruction-memory address width; memory depth = 2^IMW words.
- IW, 32, instruction width; must be a multiple of 8. BPW = IW/8 bytes per word (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin load session; sampled only in IDLE
- len  input  IMW+1  number of words to load, latched on start
- byte_valid  input  1  byte_data is valid
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- im_we  output  1  instruction-memory write strobe, one cycle per word
- im_waddr  output  IMW  word write address
- im_wdata  output  IW  assembled instruction word
- busy  output  1  session in progress; the top level gates im_cs with !busy
- done  output  1  one-cycle pulse when the session ends

Behaviour:
- Reset (asynchronous, reset_n low), effective immediately:
  - State IDLE.
  - byte_ready = 0, im_we = 0, im_waddr = 0, im_wdata = 0, busy = 0, done = 0.
  - Byte counter and word counter are cleared.
- A reset during a session aborts it. Words already written stay in memory; no done pulse is produced.
- States: IDLE, COLLECT, WRITE, DONE (plus CHECK under the optional feature).
- IDLE:
  - byte_ready = 0.
  - On start = 1, latch words = min(len, 2^IMW) and clear word address and byte count.
  - If words == 0, go to DONE; otherwise go to COLLECT.
  - busy rises on the cycle after start.
- COLLECT:
  - byte_ready = 1.
  - A byte transfers when byte_valid && byte_ready at a rising edge.
  - Bytes are little-endian: byte k of a word goes to bits [8k+7:8k].
  - Byte count runs 0..BPW-1. On the transfer that completes the word, go to WRITE.
  - byte_valid low simply stalls the collection; there is no timeout.
- WRITE:
  - Lasts one cycle, with byte_ready = 0.
  - im_we = 1, im_waddr = current word index, im_wdata = assembled word.
  - Next cycle: word index increments.
  - If the incremented index equals words, go to DONE; otherwise return to COLLECT.
- Address range and throughput:
  - im_waddr is IMW bits. A full-depth load ends at index 2^IMW; the address wraps to 0 internally but is never used for a write.
  - Peak throughput is BPW+1 cycles per word.
- DONE:
  - Lasts one cycle: done = 1, busy = 0 on the following cycle, then go to IDLE.
- Registered outputs:
  - im_we, im_waddr, im_wdata, done and busy are all registered.
  - im_wdata holds its last value outside WRITE.
- Simultaneous events:
  - start asserted while busy is ignored.
  - start asserted in the DONE cycle is ignored; it must be reasserted in IDLE.
  - byte_valid asserted while byte_ready = 0 is not consumed; the source must hold the byte.
- busy is 1 from the cycle after start is accepted through the DONE cycle inclusive.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port chk_err (1 bit). Its reset value is 0; it clears on an accepted start.
  - After the last WRITE, the loader enters CHECK with byte_ready = 1 and accepts exactly one extra byte.
  - The check passes when the 8-bit modular sum of all image bytes plus the checksum byte equals 0x00.
  - chk_err is set to 1 if the sum is nonzero and holds until the next start. The loader then goes to DONE.
  - With words == 0, CHECK is still entered; a checksum byte of 0x00 passes.
- When not defined: there is no chk_err port and no CHECK state; WRITE goes directly to DONE.

Test Plan:
- Reset mid-COLLECT (after 2 bytes of word 0):
  - Outputs go to 0 immediately.
  - No im_we pulse, no done pulse.
  - A subsequent start with len = 1 loads cleanly from address 0.
- len = 2, bytes 0x13,0x00,0x10,0x00,0x93,0x00,0x20,0x00 with byte_valid held high:
  - im_we at addr 0 with data 0x00100013, then at addr 1 with data 0x00200093.
  - byte_ready low during each WRITE cycle; done pulses once; busy returns to 0.
- Same image with byte_valid toggling 1/0 every cycle:
  - Identical writes; no byte dropped or duplicated.
- len = 0:
  - done within 2 cycles of start, no im_we.
  - len = 31 with IMW = 4: exactly 16 writes, addresses 0..15, then done.
- start pulsed during COLLECT:
  - Ignored; the session word count and addresses are unchanged.
- IMEM_LOADER_CHECKSUM_EN, len = 1, bytes 0x01,0x02,0x03,0x04 followed by checksum 0xF6:
  - chk_err = 0.
  - The same image with checksum 0x00 gives chk_err = 1; done still pulses in both cases.
